// File: rtl/calc_pkg.sv
// Shared constants and arithmetic helper for the calculator controller.
package calc_pkg;

  localparam int DEBOUNCE_DEFAULT = 16;

  localparam logic [1:0] ST_ENTER_A = 2'd0;
  localparam logic [1:0] ST_ENTER_B = 2'd1;
  localparam logic [1:0] ST_SHOW    = 2'd2;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_MUL = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;

  function automatic logic [15:0] calc_f(
    input logic [1:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0]  sum;
    logic [15:0] res;
    sum = {1'b0, a} + {1'b0, b};
    res = 16'h0000;
    case (op)
      OP_ADD:  res = {7'd0, sum};
      OP_MUL:  res = {8'h00, a} * {8'h00, b};
      OP_XOR:  res = {8'h00, a ^ b};
      default: res = 16'h0000;
    endcase
    return res;
  endfunction

  // Code 3 is unreachable; fold it back into the cycle at ADD.
  function automatic logic [1:0] next_op(input logic [1:0] op);
    logic [1:0] n;
    case (op)
      OP_ADD:  n = OP_MUL;
      OP_MUL:  n = OP_XOR;
      default: n = OP_ADD;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, counting debouncer and
// registered rising-edge press pulse.
module btn_debounce
  import calc_pkg::*;
#(
  parameter int N = DEBOUNCE_DEFAULT
) (
  input  logic clk_pi,
  input  logic rst_n_pi,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(N) + 1;

  logic          s1;
  logic          s2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 != level) begin
        if (cnt == CW'(N - 1)) begin
          level <= s2;
          cnt   <= '0;
          press <= s2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/calc_controller.sv
// Three-state calculator: enter A, enter B, show f(op, A, B) with
// chaining, driven by debounced ENTER/OP/CLEAR presses.
module calc_controller
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic        clk_pi,
  input  logic        rst_n_pi,
  input  logic [7:0]  sw_pi,
  input  logic [3:0]  btn_pi,
  output logic [15:0] display_po,
  output logic [7:0]  led_po,
  output logic [1:0]  state_po,
  output logic [1:0]  op_po
);

  logic [3:0]  press;
  logic        unused_rsvd;
  logic [1:0]  state, st_n;
  logic [1:0]  op, op_n;
  logic [7:0]  a, a_n;
  logic [7:0]  b, b_n;
  logic [15:0] res;
  logic [15:0] disp_n;
  logic [2:0]  oh_n;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.N(DEBOUNCE_CYCLES)) u_btn (
      .clk_pi   (clk_pi),
      .rst_n_pi (rst_n_pi),
      .raw      (btn_pi[i]),
      .press    (press[i])
    );
  end

  assign unused_rsvd = press[3];
  assign res = calc_f(op, a, b);

  always_comb begin
    st_n = state;
    op_n = op;
    a_n  = a;
    b_n  = b;
    if (press[2]) begin
      st_n = ST_ENTER_A;
      op_n = OP_ADD;
      a_n  = 8'h00;
      b_n  = 8'h00;
    end else if (press[0]) begin
      case (state)
        ST_ENTER_A: begin
          a_n  = sw_pi;
          st_n = ST_ENTER_B;
        end
        ST_ENTER_B: begin
          b_n  = sw_pi;
          st_n = ST_SHOW;
        end
        ST_SHOW: begin
          a_n  = res[7:0];
          st_n = ST_ENTER_B;
        end
        default: st_n = ST_ENTER_A;
      endcase
    end else begin
      if (press[1]) op_n = next_op(op);
      if (state == 2'd3) st_n = ST_ENTER_A;
    end
  end

  // Outputs are built from next-state values so they move with the FSM.
  always_comb begin
    disp_n = {8'h00, sw_pi};
    if (st_n == ST_SHOW) disp_n = calc_f(op_n, a_n, b_n);
    case (st_n)
      ST_ENTER_B: oh_n = 3'b010;
      ST_SHOW:    oh_n = 3'b100;
      default:    oh_n = 3'b001;
    endcase
  end

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      state      <= ST_ENTER_A;
      op         <= OP_ADD;
      a          <= 8'h00;
      b          <= 8'h00;
      display_po <= 16'h0000;
      led_po     <= 8'h01;
    end else begin
      state      <= st_n;
      op         <= op_n;
      a          <= a_n;
      b          <= b_n;
      display_po <= disp_n;
      led_po     <= {st_n == ST_SHOW, 1'b0, op_n, 1'b0, oh_n};
    end
  end

  assign state_po = state;
  assign op_po    = op;

endmodule

// File: tb/tb_calc_controller.sv
// Directed self-checking bench for calc_controller (DEBOUNCE_CYCLES = 4).
module tb_calc_controller;

  logic        clk;
  logic        rst_n;
  logic [7:0]  sw;
  logic [3:0]  btn;
  logic [15:0] display;
  logic [7:0]  led;
  logic [1:0]  state;
  logic [1:0]  op;

  int checks = 0;
  int errors = 0;

  calc_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_pi     (clk),
    .rst_n_pi   (rst_n),
    .sw_pi      (sw),
    .btn_pi     (btn),
    .display_po (display),
    .led_po     (led),
    .state_po   (state),
    .op_po      (op)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m);
    btn = m;
    cyc(12);
    btn = 4'b0000;
    cyc(10);
  endtask

  initial begin
    rst_n = 1'b1;
    sw    = 8'h12;
    btn   = 4'b0000;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_disp", display, 16'h0000);
    chk("rst_led", {8'h00, led}, 16'h0001);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    chk("idle_disp", display, 16'h0012);
    chk("idle_led", {8'h00, led}, 16'h0001);
    chk("idle_op", {14'd0, op}, 16'd0);
    chk("idle_state", {14'd0, state}, 16'd0);

    sw = 8'h0F;
    press(4'b0001);
    chk("entA_state", {14'd0, state}, 16'd1);
    chk("entA_led", {8'h00, led}, 16'h0002);
    chk("entA_disp", display, 16'h000F);
    sw = 8'h03;
    press(4'b0001);
    chk("add_disp", display, 16'h0012);
    chk("add_state", {14'd0, state}, 16'd2);
    chk("add_led", {8'h00, led}, 16'h0084);

    press(4'b0100);
    chk("clr_state", {14'd0, state}, 16'd0);
    chk("clr_led", {8'h00, led}, 16'h0001);
    chk("clr_disp", display, 16'h0003);

    sw = 8'hFF;
    press(4'b0001);
    press(4'b0001);
    chk("ff_add", display, 16'h01FE);
    press(4'b0010);
    chk("ff_mul", display, 16'hFE01);
    chk("ff_mul_op", {14'd0, op}, 16'd1);
    chk("ff_mul_led", {8'h00, led}, 16'h0094);
    press(4'b0010);
    chk("ff_xor", display, 16'h0000);
    chk("ff_xor_led", {8'h00, led}, 16'h00A4);
    press(4'b0010);
    chk("ff_add2", display, 16'h01FE);
    chk("ff_add2_op", {14'd0, op}, 16'd0);

    press(4'b0001);
    chk("chain_state", {14'd0, state}, 16'd1);
    chk("chain_disp", display, 16'h00FF);
    sw = 8'h02;
    press(4'b0001);
    chk("chain_add", display, 16'h0100);
    chk("chain_st2", {14'd0, state}, 16'd2);

    press(4'b0001);
    chk("chain2_state", {14'd0, state}, 16'd1);
    press(4'b0101);
    chk("clr_ent_state", {14'd0, state}, 16'd0);
    chk("clr_ent_led", {8'h00, led}, 16'h0001);
    chk("clr_ent_disp", display, 16'h0002);

    press(4'b0010);
    chk("opA_led", {8'h00, led}, 16'h0011);
    for (int i = 0; i < 20; i++) begin
      btn[0] = ~btn[0];
      cyc(2);
    end
    btn = 4'b0000;
    cyc(10);
    chk("bounce_state", {14'd0, state}, 16'd0);
    chk("bounce_led", {8'h00, led}, 16'h0011);
    press(4'b1000);
    chk("rsvd_state", {14'd0, state}, 16'd0);
    chk("rsvd_led", {8'h00, led}, 16'h0011);

    sw = 8'h05;
    press(4'b0001);
    sw = 8'h06;
    press(4'b0001);
    chk("mul_disp", display, 16'h001E);
    chk("mul_led", {8'h00, led}, 16'h0094);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_disp", display, 16'h0000);
    chk("arst_led", {8'h00, led}, 16'h0001);
    chk("arst_state", {14'd0, state}, 16'd0);
    chk("arst_op", {14'd0, op}, 16'd0);

    sw  = 8'h33;
    btn = 4'b0001;
    cyc(3);
    rst_n = 1'b1;
    cyc(12);
    chk("held_state", {14'd0, state}, 16'd1);
    chk("held_disp", display, 16'h0033);
    cyc(20);
    chk("held_once", {14'd0, state}, 16'd1);
    btn = 4'b0000;
    cyc(10);
    chk("held_rel", {14'd0, state}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_controller.md
CALC_CONTROLLER -- requirements
Module: calc_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable synchronized samples needed to accept a button level change.
REQ-002 clk_pi  input  1  system clock; all state changes on the rising edge.
REQ-003 rst_n_pi  input  1  reset, asynchronous, active-low.
REQ-004 sw_pi  input  8  operand entry switches, sampled unsynchronized as static data.
REQ-005 btn_pi  input  4  raw buttons: [0] ENTER, [1] OP, [2] CLEAR, [3] reserved (ignored).
REQ-006 display_po  output  16  registered value for the seven-segment display datapath.
REQ-007 led_po  output  8  registered status: [2:0] one-hot state, [5:4] op code, [7] result_valid, others 0.
REQ-008 state_po  output  2  current state code.
REQ-009 op_po  output  2  current operation code.

Function
REQ-010 Each button passes through a 2-flop synchronizer, then a debouncer whose level flips only after DEBOUNCE_CYCLES consecutive samples differ from the current level; any agreeing sample restarts the count.
REQ-011 A press event is a 1-cycle pulse on the debounced 0->1 transition; release generates nothing.
REQ-012 States: ENTER_A=0, ENTER_B=1, SHOW_RESULT=2; code 3 unreachable and recovers to ENTER_A.
REQ-013 Op codes: ADD=0, MUL=1, XOR=2; OP press cycles ADD->MUL->XOR->ADD in every state.
REQ-014 Arithmetic: A, B are 8-bit unsigned; ADD = zero-extended 9-bit sum, MUL = 16-bit product, XOR = zero-extended 8-bit XOR; all results 16 bits, no overflow possible.
REQ-015 ENTER_A: display_po = {8'h00, sw_pi}; ENTER press latches A <= sw_pi, goes to ENTER_B.
REQ-016 ENTER_B: display_po = {8'h00, sw_pi}; ENTER press latches B <= sw_pi, goes to SHOW_RESULT.
REQ-017 SHOW_RESULT: display_po = f(op, A, B); an OP press updates the display with the new op on the same edge as the op change.
REQ-018 SHOW_RESULT + ENTER press chains: A <= result[7:0], go to ENTER_B.
REQ-019 CLEAR press in any state: A = B = 0, op = ADD, go to ENTER_A.
REQ-020 Simultaneous press pulses, priority: CLEAR > ENTER > OP; lower-priority pulses that cycle are discarded.
REQ-021 display_po, led_po, state_po, op_po update on the same edge as the state/op registers, computed from next-state values; latency from debounced rise to output is 2 cycles.
REQ-022 result_valid (led_po[7]) is 1 only in SHOW_RESULT.

Reset
REQ-023 While rst_n_pi = 0, without a clock: state = ENTER_A, op = ADD, A = B = 0, display_po = 0, led_po = 8'h01, synchronizers, debounced levels and counters = 0.
REQ-024 A button held across reset release yields exactly one press, 2 + DEBOUNCE_CYCLES cycles after release.
REQ-025 Reset asserted mid-operation aborts immediately; no partial latch survives.

Structure
REQ-026 Shared package calc_pkg holds the state and op code constants and the default DEBOUNCE_CYCLES.
REQ-027 One sub-module, btn_debounce (synchronizer, debouncer, edge pulse), is instantiated 4 times; the FSM, operand registers and arithmetic live in calc_controller.

Verification (DEBOUNCE_CYCLES = 4)
REQ-028 Reset, sw = 0x12 -> display 0x0012, led 0x01, op ADD.
REQ-029 sw = 0x0F, ENTER; sw = 0x03, ENTER -> display 0x0012, state 2, led[7] = 1.
REQ-030 A = B = 0xFF in SHOW_RESULT, OP x3 -> display 0xFE01, then 0x0000, then 0x01FE.
REQ-031 Toggle btn[0] every 2 cycles for 40 cycles, then hold 0 -> no state change, no press.
REQ-032 Result 0x01FE, ENTER -> A = 0xFE, ENTER_B; sw = 0x02, ENTER (ADD) -> 0x0100. Pulses for CLEAR and ENTER landing in the same cycle in ENTER_B -> ENTER_A with A = B = 0.
REQ-033 rst_n_pi low mid SHOW_RESULT, no clock edge -> display 0x0000, led 0x01 immediately.
